// File: rtl/output_arbiter.sv
// Per-output switch allocator: round-robin grant held for a whole packet,
// AND-OR crossbar mux of the granted port's flits and per-port stall generation.
module output_arbiter #(
   parameter int packet_size      = 32,
   parameter int flit_size        = 4,
   parameter int flits_per_packet = packet_size / flit_size
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [4:0]             request_in,
   input  logic [5*flit_size-1:0] flit_in,
   input  logic                   downstream_ready,
   output logic [4:0]             grant,
   output logic [4:0]             stall,
   output logic [flit_size-1:0]   flit_out,
   output logic                   flit_valid
);

   localparam int count_w = (flits_per_packet > 1) ? $clog2(flits_per_packet) : 1;
   localparam logic [count_w-1:0] last_flit = count_w'(flits_per_packet - 1);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t               state_r, state_s;
   logic [4:0]           grant_r, grant_s;
   logic [count_w-1:0]   flit_count_r, flit_count_s;
   logic [2:0]           rr_pointer_r, rr_pointer_s;
   logic [2:0]           granted_idx_s;
   logic [flit_size-1:0] flit_out_s;
   logic [4:0]           stall_s;

   // First requester found scanning ptr, ptr+1, ... modulo 5.
   function automatic logic [4:0] rr_pick(input logic [4:0] req, input logic [2:0] ptr);
      logic [4:0] pick;
      logic       found;
      logic [3:0] idx;
      pick  = 5'b00000;
      found = 1'b0;
      for (int k = 0; k < 5; k++) begin
         idx = {1'b0, ptr} + 4'(k);
         if (idx >= 4'd5) begin
            idx = idx - 4'd5;
         end else begin
            idx = idx;
         end
         if (!found && req[idx[2:0]]) begin
            pick[idx[2:0]] = 1'b1;
            found          = 1'b1;
         end else begin
            found = found;
         end
      end
      return pick;
   endfunction

   function automatic logic [2:0] onehot_index(input logic [4:0] oh);
      case (oh)
         5'b00001: return 3'd0;
         5'b00010: return 3'd1;
         5'b00100: return 3'd2;
         5'b01000: return 3'd3;
         5'b10000: return 3'd4;
         default:  return 3'd0;
      endcase
   endfunction

   assign granted_idx_s = onehot_index(grant_r);

   // State, grant, flit counter and round-robin pointer registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         grant_r      <= 5'b00000;
         flit_count_r <= '0;
         rr_pointer_r <= 3'd0;
      end else begin
         state_r      <= state_s;
         grant_r      <= grant_s;
         flit_count_r <= flit_count_s;
         rr_pointer_r <= rr_pointer_s;
      end
   end

   // Arbitration and packet-length tracking
   always_comb begin
      state_s      = state_r;
      grant_s      = grant_r;
      flit_count_s = flit_count_r;
      rr_pointer_s = rr_pointer_r;
      case (state_r)
         IDLE: begin
            if (request_in != 5'b00000) begin
               grant_s      = rr_pick(request_in, rr_pointer_r);
               state_s      = BUSY;
               flit_count_s = '0;
            end else begin
               grant_s = 5'b00000;
            end
         end
         BUSY: begin
            if (downstream_ready) begin
               if (flit_count_r == last_flit) begin
                  // The port just served drops to lowest priority.
                  state_s      = IDLE;
                  grant_s      = 5'b00000;
                  flit_count_s = '0;
                  rr_pointer_s = (granted_idx_s == 3'd4) ? 3'd0 : granted_idx_s + 3'd1;
               end else begin
                  flit_count_s = flit_count_r + count_w'(1);
               end
            end else begin
               flit_count_s = flit_count_r;
            end
         end
         default: begin
            state_s      = IDLE;
            grant_s      = 5'b00000;
            flit_count_s = '0;
         end
      endcase
   end

   // Crossbar mux and stall generation
   always_comb begin
      flit_out_s = '0;
      stall_s    = 5'b00000;
      for (int i = 0; i < 5; i++) begin
         if (grant_r[i]) begin
            flit_out_s = flit_out_s | flit_in[i*flit_size +: flit_size];
         end else begin
            flit_out_s = flit_out_s;
         end
         stall_s[i] = request_in[i] && !(grant_r[i] && downstream_ready);
      end
   end

   assign grant      = grant_r;
   assign stall      = stall_s;
   assign flit_out   = flit_out_s;
   assign flit_valid = (state_r == BUSY) && downstream_ready;

endmodule

// File: tb/tb_output_arbiter.sv
// Bench for output_arbiter: directed scenarios plus a random phase, every cycle
// compared against a packet-level reference model of the arbitration rules.
module tb_output_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  request_in;
   logic [19:0] flit_in;
   logic        downstream_ready;
   logic [4:0]  grant;
   logic [4:0]  stall;
   logic [3:0]  flit_out;
   logic        flit_valid;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit         m_busy = 1'b0;
   int         m_owner = 0;
   int         m_sent = 0;
   int         m_ptr = 0;
   int         src_cnt [5];
   bit         use_src = 1'b0;
   logic [3:0] delivered [$];
   int         order [$];

   output_arbiter dut (
      .clk              (clk),
      .reset            (reset),
      .request_in       (request_in),
      .flit_in          (flit_in),
      .downstream_ready (downstream_ready),
      .grant            (grant),
      .stall            (stall),
      .flit_out         (flit_out),
      .flit_valid       (flit_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_src();
      for (int i = 0; i < 5; i++) flit_in[i*4 +: 4] = 4'(src_cnt[i] + 1);
   endtask

   task automatic model_edge();
      bit found;
      int idx;
      if (reset) begin
         m_busy = 1'b0; m_sent = 0; m_ptr = 0;
      end else if (!m_busy) begin
         if (request_in != 5'b00000) begin
            found = 1'b0;
            for (int k = 0; k < 5; k++) begin
               idx = (m_ptr + k) % 5;
               if (!found && request_in[idx]) begin
                  found = 1'b1; m_owner = idx;
               end
            end
            m_busy = 1'b1; m_sent = 0; src_cnt[m_owner] = 0;
            order.push_back(m_owner);
         end
      end else if (downstream_ready) begin
         delivered.push_back(flit_in[m_owner*4 +: 4]);
         src_cnt[m_owner]++;
         m_sent++;
         if (m_sent == 8) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % 5;
         end
      end
   endtask

   // one clock: check outputs at the falling edge, advance the model at the rising edge
   task automatic step();
      logic [4:0] e_grant, e_stall;
      logic [3:0] e_out;
      @(negedge clk);
      e_grant = 5'b00000;
      e_out   = 4'h0;
      if (m_busy) begin
         e_grant[m_owner] = 1'b1;
         e_out = flit_in[m_owner*4 +: 4];
      end
      for (int i = 0; i < 5; i++)
         e_stall[i] = request_in[i] && !(m_busy && m_owner == i && downstream_ready);
      chk("grant", 32'(grant), 32'(e_grant));
      chk("flit_valid", 32'(flit_valid), 32'(m_busy && downstream_ready));
      chk("flit_out", 32'(flit_out), 32'(e_out));
      chk("stall", 32'(stall), 32'(e_stall));
      chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      chk("valid_only_busy", 32'(flit_valid && (grant == 5'b00000)), 32'd0);
      chk("rr_pointer", 32'(dut.rr_pointer_r), 32'(m_ptr));
      @(posedge clk);
      model_edge();
      #1;
      if (use_src) drive_src();
   endtask

   task automatic chk_packet(input string tag);
      chk({tag, "_count"}, 32'(delivered.size()), 32'd8);
      for (int i = 0; i < 8 && i < delivered.size(); i++)
         chk(tag, 32'(delivered[i]), 32'(i + 1));
   endtask

   initial begin
      for (int i = 0; i < 5; i++) src_cnt[i] = 0;
      reset = 1'b1; request_in = 5'b00000; flit_in = 20'h0; downstream_ready = 1'b0;
      @(posedge clk);
      model_edge();
      #1;
      request_in = 5'b10101;
      step();
      step();
      chk("reset_grant", 32'(grant), 32'd0);
      chk("reset_stall", 32'(stall), 32'(request_in));

      // single requester on port 2
      reset = 1'b0; use_src = 1'b1; drive_src(); delivered.delete();
      request_in = 5'b00100; downstream_ready = 1'b1;
      step();
      chk("t1_grant", 32'(grant), 32'b00100);
      repeat (8) step();
      request_in = 5'b00000;
      step();
      chk("t1_idle_grant", 32'(grant), 32'd0);
      chk("t1_ptr", 32'(dut.rr_pointer_r), 32'd3);
      chk_packet("t1_flit");

      // round robin with all ports requesting
      reset = 1'b1; step(); reset = 1'b0;
      order.delete();
      request_in = 5'b11111;
      repeat (54) step();
      chk("t2_grants", 32'(order.size()), 32'd6);
      for (int i = 0; i < 6 && i < order.size(); i++)
         chk("t2_order", 32'(order[i]), 32'(i % 5));
      request_in = 5'b00000;
      step();

      // backpressure on port 1
      delivered.delete();
      request_in = 5'b00010;
      step();
      repeat (3) step();
      downstream_ready = 1'b0;
      repeat (4) begin
         step();
         chk("t3_count_held", 32'(dut.flit_count_r), 32'd3);
         chk("t3_stall1", 32'(stall[1]), 32'd1);
      end
      downstream_ready = 1'b1;
      repeat (5) step();
      request_in = 5'b00000;
      step();
      chk_packet("t3_flit");

      // grant lock after port 3 drops its request, port 4 waits
      request_in = 5'b01000;
      step();
      repeat (2) step();
      request_in = 5'b10000;
      repeat (6) begin
         chk("t4_lock", 32'(grant), 32'b01000);
         step();
      end
      step();
      chk("t4_port4", 32'(grant), 32'b10000);
      repeat (8) step();
      request_in = 5'b00000;
      step();

      // reset in the middle of a port 0 packet
      request_in = 5'b00001;
      step();
      repeat (5) step();
      reset = 1'b1; request_in = 5'b00011;
      step();
      chk("t5_grant", 32'(grant), 32'd0);
      chk("t5_valid", 32'(flit_valid), 32'd0);
      chk("t5_ptr", 32'(dut.rr_pointer_r), 32'd0);
      reset = 1'b0;
      step();
      chk("t5_first", 32'(grant), 32'b00001);
      repeat (8) step();
      step();
      chk("t5_second", 32'(grant), 32'b00010);
      repeat (8) step();
      request_in = 5'b00000;
      step();

      // pointer wrap from 4 to 0
      request_in = 5'b01000;
      step();
      repeat (8) step();
      chk("t6_ptr", 32'(dut.rr_pointer_r), 32'd4);
      request_in = 5'b00011;
      step();
      chk("t6_first", 32'(grant), 32'b00001);
      repeat (8) step();
      step();
      chk("t6_second", 32'(grant), 32'b00010);
      repeat (8) step();
      request_in = 5'b00000;
      step();

      // random traffic
      use_src = 1'b0;
      repeat (500) begin
         request_in       = 5'($urandom);
         downstream_ready = ($urandom_range(3) != 0);
         flit_in          = 20'($urandom);
         reset            = ($urandom_range(99) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
